// File: rtl/fetch_cycle.sv
// Instruction-fetch stage: PC, sync-read imem drive, IF/ID register with stall/flush/redirect.
// Optional FETCH_PERF_EN macro adds saturating fetched/bubble counters.
module fetch_cycle #(
  parameter int                   PC_W      = 9,
  parameter int                   INSTR_W   = 33,
  parameter int                   PC_STEP   = 4,
  parameter int                   RESET_PC  = 0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        PerfFetched,
  output logic [15:0]        PerfBubbles
`endif
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [PC_W-1:0] STEP  = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] RSTPC = PC_W'(RESET_PC);

  state_t state_q, state_d;
  logic [PC_W-1:0]    pcf_q, next_pc;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic               valid_q, valid_d;
  logic               boot, bubble, load;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // FSM: next state -- BOOT lasts exactly one edge
  always_comb begin
    state_d = RUN;
  end

  // FSM: outputs / datapath control
  always_comb begin
    boot   = (state_q == BOOT);
    bubble = boot || FlushD || PCSrcE;
    load   = !bubble && !StallD;
    if (boot)        next_pc = RSTPC;
    else if (PCSrcE) next_pc = PCTargetE;
    else if (StallF) next_pc = pcf_q;
    else             next_pc = pcf_q + STEP;
    // BOOT must read RESET_PC regardless of StallF so RUN sees valid data
    imem_en = !rst && (boot || PCSrcE || !StallF);
  end

  assign imem_addr = next_pc;

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = imem_rdata;
      pcd_d   = pcf_q;
      pcp4_d  = pcf_q + STEP;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q   <= RSTPC;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pcf_q   <= next_pc;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetched_q, fetched_d, bubbles_q, bubbles_d;

  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (load && fetched_q != 16'hFFFF)   fetched_d = fetched_q + 16'd1;
    if (bubble && bubbles_q != 16'hFFFF) bubbles_d = bubbles_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign PerfFetched = fetched_q;
  assign PerfBubbles = bubbles_q;
`endif

endmodule
